frame_renderer: RTL and testbench

- Downstream of the game datapath; upstream of the 160x120, 3-bit-colour VGA adapter.
- On each frame request, latches a snapshot of the game state and scans every pixel once. Game state is dude position, floor row and obstacle column with gap.
- Emits one (x, y, colour, plot) write per clock.
- The datapath may change its state freely while a frame is drawing; the snapshot prevents tearing.

---
 rtl/frame_renderer.sv | 186 ++++++++++++++++++
 tb/tb_frame_renderer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_renderer.sv
// -----------------------------------------------------------------------------
// frame_renderer
//
// Purpose:
//   Sits between the game datapath and the 160x120, 3-bit-colour VGA adapter.
//   A frame request latches a snapshot of the game state: dude position, floor
//   row, and obstacle column with its gap. The block then scans every pixel
//   once and emits one (x, y, colour, plot) write per clock. The datapath may
//   keep changing its state while a frame is drawing. Every pixel of a frame
//   is coloured from the snapshot, so frames never tear.
//
// Ports:
//   clk      in   system clock (CLOCK_50 domain)
//   reset    in   asynchronous, active-high reset
//   start    in   frame request pulse, only looked at while idle
//   dude_x   in   [7:0] dude left column
//   dude_y   in   [6:0] dude top row
//   floor_y  in   [6:0] first wall row; every row >= floor_y is wall
//   obst_x   in   [7:0] obstacle left column; the obstacle is 4 px wide
//   gap_top  in   [6:0] first row of the obstacle gap (inclusive)
//   gap_bot  in   [6:0] last row of the obstacle gap (inclusive)
//   x        out  [7:0] pixel column to the VGA adapter
//   y        out  [6:0] pixel row to the VGA adapter
//   colour   out  [2:0] pixel colour
//   plot     out  write enable to the VGA adapter
//   busy     out  high while a frame is in progress
//   done     out  one-cycle pulse after the last pixel
//
// Build option:
//   FRAME_RENDERER_BORDER_EN - when defined, a one-pixel screen border is
//   drawn in the wall colour. The dude still has priority over the border.
// -----------------------------------------------------------------------------
module frame_renderer #(
    parameter int unsigned WIDTH       = 160,
    parameter int unsigned HEIGHT      = 120,
    parameter int unsigned DUDE_SIZE   = 4,
    parameter logic [2:0]  BG_COLOUR   = 3'b000,
    parameter logic [2:0]  WALL_COLOUR = 3'b010,
    parameter logic [2:0]  DUDE_COLOUR = 3'b110
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] dude_x,
    input  logic [6:0] dude_y,
    input  logic [6:0] floor_y,
    input  logic [7:0] obst_x,
    input  logic [6:0] gap_top,
    input  logic [6:0] gap_bot,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] X_LAST  = 8'(WIDTH - 1);
    localparam logic [6:0] Y_LAST  = 7'(HEIGHT - 1);
    localparam logic [8:0] DUDE_W9 = 9'(DUDE_SIZE);
    localparam logic [7:0] DUDE_H8 = 8'(DUDE_SIZE);
    localparam logic [8:0] OBST_W9 = 9'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_cx;
    logic [6:0] r_cy;

    // Snapshot of the game state, frozen for the whole frame.
    logic [7:0] r_dude_x;
    logic [6:0] r_dude_y;
    logic [6:0] r_floor_y;
    logic [7:0] r_obst_x;
    logic [6:0] r_gap_top;
    logic [6:0] r_gap_bot;

    logic       w_dude_hit;
    logic       w_obst_hit;
    logic       w_wall_hit;
    logic [2:0] w_colour;

    // Colour of the pixel under the scan counters.
    // The sprite and obstacle bounds are compared one bit wider than the
    // operands, so that a right or bottom edge beyond 255/127 cannot wrap.
    // Off-screen parts are then clipped naturally by the scan range.
    always_comb begin
        w_dude_hit = ({1'b0, r_cx} >= {1'b0, r_dude_x}) &&
                     ({1'b0, r_cx} <  ({1'b0, r_dude_x} + DUDE_W9)) &&
                     ({1'b0, r_cy} >= {1'b0, r_dude_y}) &&
                     ({1'b0, r_cy} <  ({1'b0, r_dude_y} + DUDE_H8));
        // An inverted gap (top > bot) never matches, which gives a solid column.
        w_obst_hit = ({1'b0, r_cx} >= {1'b0, r_obst_x}) &&
                     ({1'b0, r_cx} <  ({1'b0, r_obst_x} + OBST_W9)) &&
                     !((r_cy >= r_gap_top) && (r_cy <= r_gap_bot));
        // A floor_y beyond the last row can never match, so no floor is drawn.
        w_wall_hit = (r_cy >= r_floor_y) || w_obst_hit;
`ifdef FRAME_RENDERER_BORDER_EN
        if ((r_cx == 8'd0) || (r_cx == X_LAST) || (r_cy == 7'd0) || (r_cy == Y_LAST)) begin
            w_wall_hit = 1'b1;
        end
`endif
        if (w_dude_hit) begin
            w_colour = DUDE_COLOUR;
        end else if (w_wall_hit) begin
            w_colour = WALL_COLOUR;
        end else begin
            w_colour = BG_COLOUR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cx      <= 8'd0;
            r_cy      <= 7'd0;
            r_dude_x  <= 8'd0;
            r_dude_y  <= 7'd0;
            r_floor_y <= 7'd0;
            r_obst_x  <= 8'd0;
            r_gap_top <= 7'd0;
            r_gap_bot <= 7'd0;
            x         <= 8'd0;
            y         <= 7'd0;
            colour    <= 3'd0;
            plot      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    plot <= 1'b0;
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        r_dude_x  <= dude_x;
                        r_dude_y  <= dude_y;
                        r_floor_y <= floor_y;
                        r_obst_x  <= obst_x;
                        r_gap_top <= gap_top;
                        r_gap_bot <= gap_bot;
                        r_cx      <= 8'd0;
                        r_cy      <= 7'd0;
                        busy      <= 1'b1;
                        r_state   <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    x      <= r_cx;
                    y      <= r_cy;
                    colour <= w_colour;
                    plot   <= 1'b1;
                    busy   <= 1'b1;
                    done   <= 1'b0;
                    if (r_cx == X_LAST) begin
                        r_cx <= 8'd0;
                        if (r_cy == Y_LAST) begin
                            r_cy    <= 7'd0;
                            r_state <= S_DONE;
                        end else begin
                            r_cy <= r_cy + 7'd1;
                        end
                    end else begin
                        r_cx <= r_cx + 8'd1;
                    end
                end
                S_DONE: begin
                    // The last write has gone out. Flag completion for one
                    // cycle, then go idle.
                    plot    <= 1'b0;
                    done    <= 1'b1;
                    busy    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_renderer.sv
module tb_frame_renderer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] dude_x;
    logic [6:0] dude_y;
    logic [6:0] floor_y;
    logic [7:0] obst_x;
    logic [6:0] gap_top;
    logic [6:0] gap_bot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    frame_renderer dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .dude_x  (dude_x),
        .dude_y  (dude_y),
        .floor_y (floor_y),
        .obst_x  (obst_x),
        .gap_top (gap_top),
        .gap_bot (gap_bot),
        .x       (x),
        .y       (y),
        .colour  (colour),
        .plot    (plot),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

`ifdef FRAME_RENDERER_BORDER_EN
    localparam logic [2:0] EDGE_COL = 3'b010;
`else
    localparam logic [2:0] EDGE_COL = 3'b000;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0]  fb [0:159][0:119];
    int          plots;
    int          done_k;
    int          busy_low;
    int          bad_xy;
    logic [14:0] first_xy;
    logic [14:0] last_xy;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Requests one frame and captures every write into fb.
    // Cycle k counts the clock edges after the edge that sampled start.
    // poke_at > 0 : at that cycle, move the dude and lower the floor, and
    //               pulse start again.
    // abort_at > 0: at that cycle, assert reset and stop.
    task automatic run_frame(input int poke_at, input int abort_at);
        for (int i = 0; i < 160; i++) begin
            for (int j = 0; j < 120; j++) begin
                fb[i][j] = 3'b111;
            end
        end
        plots    = 0;
        done_k   = -1;
        busy_low = 0;
        bad_xy   = 0;
        first_xy = '1;
        last_xy  = '1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 1; k <= 20000; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (plot) begin
                if (plots == 0) first_xy = {x, y};
                last_xy = {x, y};
                plots++;
                if (x < 8'd160 && y < 7'd120) fb[x][y] = colour;
                else bad_xy++;
            end
            if (!busy) busy_low++;
            if (k == poke_at) begin
                dude_x  = 8'd80;
                floor_y = 7'd60;
                start   = 1'b1;
            end
            if (k == abort_at) begin
                reset = 1'b1;
                #1;
                check_eq("abort_plot", {31'd0, plot}, 32'd0);
                check_eq("abort_busy", {31'd0, busy}, 32'd0);
                check_eq("abort_done", {31'd0, done}, 32'd0);
                check_eq("abort_x", {24'd0, x}, 32'd0);
                break;
            end
            if (done) begin
                done_k = k;
                break;
            end
        end
    endtask

    task automatic check_frame(input string tag);
        check_eq({tag, "_plots"}, plots, 19200);
        check_eq({tag, "_done_cycle"}, done_k, 19201);
        check_eq({tag, "_busy_low"}, busy_low, 0);
        check_eq({tag, "_offscreen"}, bad_xy, 0);
        check_eq({tag, "_first_xy"}, {17'd0, first_xy}, {17'd0, 8'd0, 7'd0});
        check_eq({tag, "_last_xy"}, {17'd0, last_xy}, {17'd0, 8'd159, 7'd119});
    endtask

    initial begin
        int extra;
        reset   = 1'b1;
        start   = 1'b0;
        dude_x  = 8'd0;
        dude_y  = 7'd0;
        floor_y = 7'd0;
        obst_x  = 8'd0;
        gap_top = 7'd0;
        gap_bot = 7'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_x", {24'd0, x}, 32'd0);
        check_eq("rst_y", {25'd0, y}, 32'd0);
        check_eq("rst_colour", {29'd0, colour}, 32'd0);
        check_eq("rst_plot", {31'd0, plot}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_plot", {31'd0, plot}, 32'd0);

        // Frame A: basic frame, with the state changed and start pulsed mid-frame.
        dude_x = 8'd10; dude_y = 7'd20; floor_y = 7'd100;
        obst_x = 8'd200; gap_top = 7'd0; gap_bot = 7'd0;
        run_frame(5000, 0);
        check_frame("A");
        check_eq("A(10,20)", {29'd0, fb[10][20]}, 32'd6);
        check_eq("A(13,23)", {29'd0, fb[13][23]}, 32'd6);
        check_eq("A(14,20)", {29'd0, fb[14][20]}, 32'd0);
        check_eq("A(0,100)", {29'd0, fb[0][100]}, 32'd2);
        check_eq("A(40,80)_snapshot", {29'd0, fb[40][80]}, 32'd0);
        check_eq("A(80,20)_snapshot", {29'd0, fb[80][20]}, 32'd0);
        @(negedge clk);
        check_eq("A_busy_after", {31'd0, busy}, 32'd0);
        check_eq("A_done_after", {31'd0, done}, 32'd0);
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (plot || busy) extra++;
        end
        check_eq("A_no_second_frame", extra, 0);

        // Frame B: dude now at column 80, obstacle with a gap.
        dude_y = 7'd20; floor_y = 7'd120;
        obst_x = 8'd50; gap_top = 7'd40; gap_bot = 7'd59;
        run_frame(0, 0);
        check_frame("B");
        check_eq("B(80,20)", {29'd0, fb[80][20]}, 32'd6);
        check_eq("B(83,23)", {29'd0, fb[83][23]}, 32'd6);
        check_eq("B(10,20)", {29'd0, fb[10][20]}, 32'd0);
        check_eq("B(50,39)", {29'd0, fb[50][39]}, 32'd2);
        check_eq("B(53,40)", {29'd0, fb[53][40]}, 32'd0);
        check_eq("B(52,59)", {29'd0, fb[52][59]}, 32'd0);
        check_eq("B(53,60)", {29'd0, fb[53][60]}, 32'd2);
        check_eq("B(54,10)", {29'd0, fb[54][10]}, 32'd0);
        check_eq("B(80,60)", {29'd0, fb[80][60]}, 32'd0);
        check_eq("B(159,60)", {29'd0, fb[159][60]}, {29'd0, EDGE_COL});
        check_eq("B(100,119)", {29'd0, fb[100][119]}, {29'd0, EDGE_COL});

        // Frame C: dude in the corner, aborted by reset at cycle 9000.
        dude_x = 8'd0; dude_y = 7'd0; floor_y = 7'd120;
        obst_x = 8'd200; gap_top = 7'd0; gap_bot = 7'd0;
        run_frame(0, 9000);
        check_eq("C_plots_before_abort", plots, 9000);
        check_eq("C(0,0)", {29'd0, fb[0][0]}, 32'd6);
        check_eq("C(3,3)", {29'd0, fb[3][3]}, 32'd6);
        check_eq("C(4,0)", {29'd0, fb[4][0]}, {29'd0, EDGE_COL});
        check_eq("C(5,0)", {29'd0, fb[5][0]}, {29'd0, EDGE_COL});
        check_eq("C(5,1)", {29'd0, fb[5][1]}, 32'd0);
        extra = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done || plot) extra++;
        end
        check_eq("C_quiet_in_reset", extra, 0);
        reset = 1'b0;
        @(negedge clk);

        // Frame D: clipped dude at bottom-right, full obstacle column.
        dude_x = 8'd158; dude_y = 7'd118; floor_y = 7'd110;
        obst_x = 8'd20; gap_top = 7'd50; gap_bot = 7'd10;
        run_frame(0, 0);
        check_frame("D");
        check_eq("D(159,119)", {29'd0, fb[159][119]}, 32'd6);
        check_eq("D(158,118)", {29'd0, fb[158][118]}, 32'd6);
        check_eq("D(157,119)", {29'd0, fb[157][119]}, 32'd2);
        check_eq("D(100,109)", {29'd0, fb[100][109]}, 32'd0);
        check_eq("D(100,110)", {29'd0, fb[100][110]}, 32'd2);
        check_eq("D(21,55)", {29'd0, fb[21][55]}, 32'd2);
        check_eq("D(21,5)", {29'd0, fb[21][5]}, 32'd2);
        check_eq("D(24,5)", {29'd0, fb[24][5]}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
